// File: rtl/kb_pkg.sv
// Shared PS/2 scan-code constants, prefix FSM states and the 9-bit {shift, scancode} word.
// Also used by the downstream ASCII converter.
package kb_pkg;

    localparam logic [7:0] BRK      = 8'hF0;
    localparam logic [7:0] EXT      = 8'hE0;
    localparam logic [7:0] LSHIFT   = 8'h12;
    localparam logic [7:0] RSHIFT   = 8'h59;
    localparam logic [7:0] CAPS     = 8'h58;
    localparam logic [7:0] KP_ENTER = 8'h5A;
    localparam logic [7:0] KP_SLASH = 8'h4A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_e;

    typedef logic [8:0] kb_word;

    function automatic logic is_letter(input logic [7:0] code);
        case (code)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kb_fifo.sv
// Show-ahead FIFO of kb_word entries; the head is read combinationally.
// Pointers carry one extra MSB so full and empty are distinguishable after wrap.
module kb_fifo
    import kb_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_i,
    input  kb_word wr_data_i,
    input  logic   rd_i,
    output kb_word rd_data_o,
    output logic   empty_o,
    output logic   full_o
);

    localparam int DEPTH = 1 << ADDR_W;

    kb_word          mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            do_wr, do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // A pop frees the slot the simultaneous push lands in, so a full FIFO still accepts it.
    assign do_rd = rd_i && !empty_o;
    assign do_wr = wr_i && (!full_o || do_rd);

    assign wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, do_wr};
    assign rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, do_rd};

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/kb_scan_decoder.sv
// Strips F0/E0 prefixes from PS/2 bytes, tracks shift and queues make codes as {shift, scancode}.
// Define KB_CAPS_LOCK_EN to let scancode 58 toggle caps lock, which inverts bit 8 for letters.
module kb_scan_decoder
    import kb_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       rd,
    output logic [8:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_on
);

    kb_state_e state_q, state_d;
    logic      shift_l_q, shift_l_d;
    logic      shift_r_q, shift_r_d;
    logic      shift_on_q;
    logic      overflow_q;
    logic      push;
    logic      caps_hit;
    logic      caps_flip;
    kb_word    push_word;

`ifdef KB_CAPS_LOCK_EN
    logic caps_q;

    assign caps_hit  = rx_done_tick && (state_q == ST_IDLE) && (rx_data == CAPS);
    assign caps_flip = caps_q && is_letter(rx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            caps_q <= 1'b0;
        end else if (caps_hit) begin
            caps_q <= ~caps_q;
        end
    end
`else
    assign caps_hit  = 1'b0;
    assign caps_flip = 1'b0;
`endif

    // Bit 8 is the shift state held before this byte arrived.
    assign push_word = {shift_on_q ^ caps_flip, rx_data};

    always_comb begin
        state_d   = state_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        push      = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == BRK)         state_d = ST_BRK;
                    else if (rx_data == EXT)    state_d = ST_EXT;
                    else if (rx_data == LSHIFT) shift_l_d = 1'b1;
                    else if (rx_data == RSHIFT) shift_r_d = 1'b1;
                    else if (!caps_hit)         push = 1'b1;
                end
                ST_BRK: begin
                    if (rx_data == LSHIFT) shift_l_d = 1'b0;
                    if (rx_data == RSHIFT) shift_r_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        push    = (rx_data == KP_ENTER) || (rx_data == KP_SLASH);
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            shift_on_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            shift_on_q <= shift_l_d | shift_r_d;
            // A full FIFO is never empty, so a pending rd always makes room.
            if (push && full && !rd) begin
                overflow_q <= 1'b1;
            end
        end
    end

    kb_fifo #(.ADDR_W(ADDR_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (push),
        .wr_data_i (push_word),
        .rd_i      (rd),
        .rd_data_o (rd_data),
        .empty_o   (empty),
        .full_o    (full)
    );

    assign shift_on = shift_on_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_kb_scan_decoder.sv
// Bench for kb_scan_decoder: directed scenarios plus random byte streams against a queue model.
// Build with KB_CAPS_LOCK_EN defined to exercise the caps-lock variant.
module tb_kb_scan_decoder;

    localparam int DEPTH = 16;

`ifdef KB_CAPS_LOCK_EN
    localparam bit CAPS_EN = 1'b1;
`else
    localparam bit CAPS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic       rd = 1'b0;
    logic [8:0] rd_data;
    logic       empty, full, overflow, shift_on;

    int n_checks = 0;
    int n_errors = 0;

    kb_scan_decoder #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .rd           (rd),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .shift_on     (shift_on)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];
    bit m_sl, m_sr, m_caps, m_ovf, m_brk, m_ext;
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    function automatic bit letter(input logic [7:0] b);
        foreach (letters[i]) if (letters[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_sl = 0; m_sr = 0; m_caps = 0; m_ovf = 0; m_brk = 0; m_ext = 0;
    endtask

    task automatic model_edge(input bit t, input logic [7:0] d, input bit r);
        bit pop, push, sh;
        logic [8:0] w;
        sh   = m_sl | m_sr;
        pop  = r && (exp_q.size() != 0);
        push = 0;
        w    = {(sh ^ (m_caps && letter(d))), d};
        if (t) begin
            if (!m_brk && !m_ext) begin
                if (d == 8'hF0) m_brk = 1;
                else if (d == 8'hE0) m_ext = 1;
                else if (d == 8'h12) m_sl = 1;
                else if (d == 8'h59) m_sr = 1;
                else if (CAPS_EN && d == 8'h58) m_caps = !m_caps;
                else push = 1;
            end else if (m_brk && !m_ext) begin
                if (d == 8'h12) m_sl = 0;
                if (d == 8'h59) m_sr = 0;
                m_brk = 0;
            end else if (m_ext && !m_brk) begin
                if (d == 8'hF0) m_brk = 1;
                else begin
                    push = (d == 8'h5A) || (d == 8'h4A);
                    m_ext = 0;
                end
            end else begin
                m_brk = 0; m_ext = 0;
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else m_ovf = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("empty", {8'd0, empty}, {8'd0, exp_q.size() == 0});
        chk("full", {8'd0, full}, {8'd0, exp_q.size() == DEPTH});
        chk("overflow", {8'd0, overflow}, {8'd0, m_ovf});
        chk("shift_on", {8'd0, shift_on}, {8'd0, m_sl | m_sr});
        if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q[0]);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit t, input logic [7:0] d, input bit r);
        rx_done_tick = t; rx_data = d; rd = r;
        @(posedge clk);
        model_edge(t, d, r);
        #1;
        rx_done_tick = 0; rd = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; rx_done_tick = 0; rd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0: return 8'hF0;
            1: return 8'hE0;
            2: return 8'h12;
            3: return 8'h59;
            4: return 8'h58;
            5: return ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h4A;
            6, 7: return letters[$urandom_range(0, 25)];
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        // reset state
        chk("rst_empty", {8'd0, empty}, 9'd1);
        chk("rst_full", {8'd0, full}, 9'd0);
        chk("rst_overflow", {8'd0, overflow}, 9'd0);
        chk("rst_shift_on", {8'd0, shift_on}, 9'd0);
        chk("rst_rd_data", rd_data, 9'h000);

        // single make code
        step(1, 8'h1C, 0);
        settle();
        chk("t1_empty", {8'd0, empty}, 9'd0);
        chk("t1_head", rd_data, 9'h01C);
        step(0, 8'h00, 1);
        settle();
        chk("t1_pop_empty", {8'd0, empty}, 9'd1);

        // shift press / release
        step(1, 8'h12, 0);
        settle();
        chk("t2_shift_set", {8'd0, shift_on}, 9'd1);
        step(1, 8'h1C, 0);
        step(1, 8'hF0, 0);
        step(1, 8'h1C, 0);
        step(1, 8'hF0, 0);
        step(1, 8'h12, 0);
        settle();
        chk("t2_shift_clr", {8'd0, shift_on}, 9'd0);
        step(1, 8'h1C, 0);
        settle();
        chk("t2_head0", rd_data, 9'h11C);
        step(0, 8'h00, 1);
        settle();
        chk("t2_head1", rd_data, 9'h01C);
        step(0, 8'h00, 1);

        // extended prefixes
        foreach (letters[i]) if (i < 1) ;
        step(1, 8'hE0, 0); step(1, 8'h75, 0);
        step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
        step(1, 8'hE0, 0); step(1, 8'h5A, 0);
        settle();
        chk("t3_head", rd_data, 9'h05A);
        step(0, 8'h00, 1);
        settle();
        chk("t3_empty", {8'd0, empty}, 9'd1);

        // fill, simultaneous push/pop while full, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, 8'h15 + 8'(i), 0);
        settle();
        chk("t4_full", {8'd0, full}, 9'd1);
        chk("t4_no_ovf", {8'd0, overflow}, 9'd0);
        step(1, 8'h25, 1);
        settle();
        chk("t5_full_kept", {8'd0, full}, 9'd1);
        chk("t5_no_ovf", {8'd0, overflow}, 9'd0);
        chk("t5_head", rd_data, 9'h016);
        step(1, 8'h26, 0);
        settle();
        chk("t4_ovf", {8'd0, overflow}, 9'd1);
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            chk("t4_drain", rd_data, 9'h016 + 9'(i));
            step(0, 8'h00, 1);
        end
        settle();
        chk("t4_drained", {8'd0, empty}, 9'd1);

        // rd on empty, push+pop on empty, ignored data without tick
        step(0, 8'h00, 1);
        step(1, 8'h1D, 1);
        settle();
        chk("empty_pushpop", rd_data, 9'h01D);
        step(0, 8'h00, 1);
        repeat (3) step(0, 8'hF0, 0);
        step(1, 8'h1C, 0);
        settle();
        chk("no_tick", rd_data, 9'h01C);
        step(0, 8'h00, 1);

        // reset in the middle of an extended sequence
        step(1, 8'hE0, 0);
        do_reset();
        step(1, 8'h16, 0);
        settle();
        chk("t5_rst_mid", rd_data, 9'h016);
        chk("t5_ovf_clr", {8'd0, overflow}, 9'd0);
        step(0, 8'h00, 1);

        // caps lock
        step(1, 8'h58, 0); step(1, 8'h1C, 0); step(1, 8'h16, 0);
        settle();
`ifdef KB_CAPS_LOCK_EN
        chk("t6_w0", rd_data, 9'h11C);
        step(0, 8'h00, 1); settle();
        chk("t6_w1", rd_data, 9'h016);
        step(0, 8'h00, 1);
`else
        chk("t6_w0", rd_data, 9'h058);
        step(0, 8'h00, 1); settle();
        chk("t6_w1", rd_data, 9'h01C);
        step(0, 8'h00, 1); settle();
        chk("t6_w2", rd_data, 9'h016);
        step(0, 8'h00, 1);
`endif

        // random streams
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 2) != 0, rand_byte(),
                 (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
